// File: rtl/deserial_rx.sv
//------------------------------------------------------------------------------
// Module   : deserial_rx
// Purpose  : Serial-to-parallel frame receiver. It collects DATA_W serial bits,
//            delivers the word on a valid/ready output and flags aborted frames
//            and dropped words.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active low
//            ser_data   - serial data bit
//            ser_valid  - ser_data carries a frame bit this cycle
//            ready_in   - downstream accepts data_out this cycle
//            data_out   - reassembled word [DATA_W-1:0]
//            valid_out  - data_out holds an unconsumed word
//            busy_out   - a frame is being received
//            frame_err  - one-cycle pulse: frame aborted or parity error
//            overrun    - one-cycle pulse: completed word dropped
// Params   : DATA_W (2..16), MSB_FIRST (0: first bit -> data_out[0])
// Macro    : DESERIAL_RX_PARITY_EN adds one trailing even-parity bit per frame
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module deserial_rx #(
   parameter int DATA_W    = 4,
   parameter int MSB_FIRST = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ser_data,
   input  logic              ser_valid,
   input  logic              ready_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              busy_out,
   output logic              frame_err,
   output logic              overrun
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
`ifdef DESERIAL_RX_PARITY_EN
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2
`else
      S_SHIFT  = 2'd1
`endif
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_next;
   logic [DATA_W-1:0] w_shift_in;
   logic [DATA_W-1:0] w_base;
   logic [DATA_W-1:0] w_word;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_frame_err;
   logic              r_overrun;
   logic              w_complete;
   logic              w_err;

   // A new frame starts from an empty register so stale bits never leak in.
   assign w_base = (r_state == S_IDLE) ? '0 : r_shift;

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         // Shift left: the first bit migrates up to data_out[DATA_W-1].
         assign w_shift_in = {w_base[DATA_W-2:0], ser_data};
      end else begin : g_lsb_first
         // Shift right: the first bit migrates down to data_out[0].
         assign w_shift_in = {ser_data, w_base[DATA_W-1:1]};
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_shift_next = r_shift;
      w_word       = r_shift;
      w_complete   = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ser_valid) begin
               w_shift_next = w_shift_in;
               w_cnt_next   = CNT_W'(1);
               w_state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (ser_valid) begin
               w_shift_next = w_shift_in;
               if (r_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef DESERIAL_RX_PARITY_EN
                  w_cnt_next   = CNT_W'(DATA_W);
                  w_state_next = S_PARITY;
`else
                  w_word       = w_shift_in;
                  w_complete   = 1'b1;
                  w_cnt_next   = '0;
                  w_shift_next = '0;
                  w_state_next = S_IDLE;
`endif
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end else begin
               w_err        = 1'b1;
               w_cnt_next   = '0;
               w_shift_next = '0;
               w_state_next = S_IDLE;
            end
         end
`ifdef DESERIAL_RX_PARITY_EN
         S_PARITY: begin
            w_cnt_next   = '0;
            w_shift_next = '0;
            w_state_next = S_IDLE;
            // Even parity: data bits plus parity bit must hold an even count of ones.
            if (ser_valid && !(^{r_shift, ser_data})) begin
               w_complete = 1'b1;
            end else begin
               w_err = 1'b1;
            end
         end
`endif
         default: begin
            w_cnt_next   = '0;
            w_shift_next = '0;
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_shift <= w_shift_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_err;
         r_overrun   <= 1'b0;
         if (w_complete) begin
            // A word may load when the slot is empty or being emptied this edge.
            if (!r_valid || ready_in) begin
               r_data  <= w_word;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && ready_in) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_out  = r_data;
   assign valid_out = r_valid;
   assign busy_out  = (r_state != S_IDLE);
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_deserial_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_deserial_rx
// Purpose  : Self-checking bench for deserial_rx with a queue-based model,
//            directed scenarios and a randomized phase.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_deserial_rx;

   localparam int DW   = 4;
   localparam int MSBF = 0;
`ifdef DESERIAL_RX_PARITY_EN
   localparam int FL = DW + 1;
`else
   localparam int FL = DW;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ser_data = 1'b0;
   logic          ser_valid = 1'b0;
   logic          ready_in = 1'b0;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic          busy_out;
   logic          frame_err;
   logic          overrun;

   int n_checks = 0;
   int n_err    = 0;

   deserial_rx #(.DATA_W(DW), .MSB_FIRST(MSBF)) dut (
      .clk       (clk),
      .rst       (rst),
      .ser_data  (ser_data),
      .ser_valid (ser_valid),
      .ready_in  (ready_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .busy_out  (busy_out),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a frame is just the list of bits seen so far.
   bit            q[$];
   logic [DW-1:0] m_data  = '0;
   logic          m_valid = 1'b0;
   logic          m_err   = 1'b0;
   logic          m_ovr   = 1'b0;

   always @(posedge clk or negedge rst) begin
      logic          done;
      logic          par;
      logic [DW-1:0] word;
      if (!rst) begin
         q.delete();
         m_data  = '0;
         m_valid = 1'b0;
         m_err   = 1'b0;
         m_ovr   = 1'b0;
      end else begin
         done  = 1'b0;
         word  = '0;
         m_err = 1'b0;
         m_ovr = 1'b0;
         if (ser_valid) begin
            q.push_back(ser_data);
            if (q.size() == FL) begin
               par = 1'b0;
               foreach (q[k]) par ^= q[k];
               for (int i = 0; i < DW; i++) word[(MSBF != 0) ? (DW - 1 - i) : i] = q[i];
               if (FL == DW || par == 1'b0) done = 1'b1;
               else m_err = 1'b1;
               q.delete();
            end
         end else if (q.size() > 0) begin
            m_err = 1'b1;
            q.delete();
         end
         if (done) begin
            if (!m_valid || ready_in) begin
               m_data  = word;
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_valid && ready_in) begin
            m_valid = 1'b0;
         end
      end
   end

   // Continuous comparison against the model.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("m_busy", busy_out, (q.size() > 0));
         chk("m_valid", valid_out, m_valid);
         chk("m_data", data_out, m_data);
         chk("m_frame_err", frame_err, m_err);
         chk("m_overrun", overrun, m_ovr);
      end
   end

   task automatic cyc(input logic v, input logic d, input logic r);
      @(negedge clk);
      ser_valid = v;
      ser_data  = d;
      ready_in  = r;
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      settle();
      chk("rst_valid", valid_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_data", data_out, 0);
      @(negedge clk);
      rst = 1'b1;

`ifdef DESERIAL_RX_PARITY_EN
      // 4'h5 with correct parity 0
      cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 0, 1);
      settle();
      chk("par_ok_valid", valid_out, 1);
      chk("par_ok_data", data_out, 4'h5);
      cyc(0, 0, 1);
      settle();
      chk("par_ok_drain", valid_out, 0);
      // 4'h5 with wrong parity 1
      cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 1, 1);
      settle();
      chk("par_bad_err", frame_err, 1);
      chk("par_bad_valid", valid_out, 0);
      cyc(0, 0, 1);
`else
      // Bits 1,0,1,0 LSB first -> 4'h5
      cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 0, 1);
      settle();
      chk("w5_valid", valid_out, 1);
      chk("w5_data", data_out, 4'h5);

      // Back-to-back frames 4'hA then 4'h6
      cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 1, 1);
      settle();
      chk("b2b_a_data", data_out, 4'hA);
      chk("b2b_a_valid", valid_out, 1);
      cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 1, 1); cyc(1, 0, 1);
      settle();
      chk("b2b_6_data", data_out, 4'h6);
      chk("b2b_6_ovr", overrun, 0);
      cyc(0, 0, 1);

      // Overrun: 4'h9 then 4'h3 with ready low
      cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0);
      settle();
      chk("ovr_9_data", data_out, 4'h9);
      cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0);
      settle();
      chk("ovr_pulse", overrun, 1);
      chk("ovr_keep_data", data_out, 4'h9);
      chk("ovr_keep_valid", valid_out, 1);
      cyc(0, 0, 1);
      settle();
      chk("ovr_drained", valid_out, 0);
      chk("ovr_cleared", overrun, 0);

      // Abort after 2 bits, then 4'hC
      cyc(1, 1, 1); cyc(1, 0, 1); cyc(0, 0, 1);
      settle();
      chk("abort_err", frame_err, 1);
      chk("abort_busy", busy_out, 0);
      chk("abort_valid", valid_out, 0);
      cyc(0, 0, 1);
      settle();
      chk("abort_err_1cyc", frame_err, 0);
      cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 1, 1);
      settle();
      chk("c_data", data_out, 4'hC);
      chk("c_valid", valid_out, 1);

      // Asynchronous reset mid-frame with a word pending
      cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_data", data_out, 0);
      chk("arst_valid", valid_out, 0);
      chk("arst_busy", busy_out, 0);
      chk("arst_err", frame_err, 0);
      chk("arst_ovr", overrun, 0);
      @(negedge clk);
      rst       = 1'b1;
      ser_valid = 1'b0;
      cyc(0, 0, 1);
      cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1);
      settle();
      chk("post_rst_data", data_out, 4'h1);
      chk("post_rst_valid", valid_out, 1);
`endif

      // Randomized phase, model-checked every cycle
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         ser_valid = ($urandom_range(0, 99) < 88);
         ser_data  = $urandom_range(0, 1);
         ready_in  = ($urandom_range(0, 99) < 55);
         rst       = ($urandom_range(0, 499) != 0);
      end
      @(negedge clk);
      rst       = 1'b1;
      ser_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
